// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage MIPS pipeline: load-use/branch-operand
// stalls, branch/jump flushes, data-memory wait states, and stall/flush performance counters.
//
//    state   | meaning
//    --------+----------------------------------------------------------------
//    INIT    | post-reset drain: PC held, IF/ID and ID/EX flushed
//    RUN     | normal issue; hazard stalls and redirect flushes resolved here
//    MEM_WAIT| whole pipeline frozen until dmem_ready or the wait limit expires
module pipeline_hazard_ctrl #(
   parameter int INIT_CYCLES = 4,
   parameter int TIMEOUT     = 255,
   parameter int CW          = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [4:0]    Rs_ID,
   input  logic [4:0]    Rt_ID,
   input  logic          use_rs_ID,
   input  logic          use_rt_ID,
   input  logic          branch_ID,
   input  logic          branch_taken_ID,
   input  logic          jump_ID,
   input  logic          data_read_EX,
   input  logic          reg_write_EX,
   input  logic [4:0]    Write_regnum_EX,
   input  logic          data_read_MEM,
   input  logic [4:0]    Write_regnum_MEM,
   input  logic          mem_req_MEM,
   input  logic          dmem_ready,
   output logic          PC_write_en,
   output logic          IF_ID_write_en,
   output logic          IF_ID_flush,
   output logic          stall_flush,
   output logic          ID_EX_write_en,
   output logic          EX_MEM_write_en,
   output logic          MEM_WB_write_en,
   output logic [1:0]    pipe_state,
   output logic [CW-1:0] stall_cycles,
   output logic [CW-1:0] flush_count,
   output logic          mem_timeout
);
   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_RUN  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   localparam int            IW        = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
   localparam logic [7:0]    WAIT_LAST = 8'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_MAX   = '1;

   state_t          state_q, state_d;
   logic [IW-1:0]   init_cnt_q, init_cnt_d;
   logic [7:0]      wait_cnt_q, wait_cnt_d;
   logic [CW-1:0]   stall_q, stall_d;
   logic [CW-1:0]   flush_q, flush_d;
   logic            timeout_q, timeout_d;

   function automatic logic reads_reg(input logic [4:0] r, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic urs, input logic urt);
      return (r != 5'd0) && ((urs && (rs == r)) || (urt && (rt == r)));
   endfunction

   logic hz_load_use, hz_alu_br, hz_load_br, hazard, redirect, mem_stall;

   assign hz_load_use = data_read_EX &
                        reads_reg(Write_regnum_EX, Rs_ID, Rt_ID, use_rs_ID, use_rt_ID);
   assign hz_alu_br   = branch_ID & reg_write_EX & ~data_read_EX &
                        reads_reg(Write_regnum_EX, Rs_ID, Rt_ID, use_rs_ID, use_rt_ID);
   assign hz_load_br  = branch_ID & data_read_MEM &
                        reads_reg(Write_regnum_MEM, Rs_ID, Rt_ID, use_rs_ID, use_rt_ID);
   assign hazard      = hz_load_use | hz_alu_br | hz_load_br;
   assign redirect    = branch_taken_ID | jump_ID;
   assign mem_stall   = mem_req_MEM & ~dmem_ready;

   always_comb begin
      PC_write_en     = 1'b1;
      IF_ID_write_en  = 1'b1;
      IF_ID_flush     = 1'b0;
      stall_flush     = 1'b0;
      ID_EX_write_en  = 1'b1;
      EX_MEM_write_en = 1'b1;
      MEM_WB_write_en = 1'b1;
      state_d         = state_q;
      init_cnt_d      = init_cnt_q;
      wait_cnt_d      = wait_cnt_q;
      timeout_d       = timeout_q;

      case (state_q)
         ST_INIT: begin
            PC_write_en = 1'b0;
            IF_ID_flush = 1'b1;
            stall_flush = 1'b1;
            if (init_cnt_q == INIT_LAST) state_d = ST_RUN;
            else                         init_cnt_d = init_cnt_q + IW'(1);
         end
         ST_RUN, ST_WAIT: begin
            if ((state_q == ST_WAIT && !dmem_ready) || (state_q == ST_RUN && mem_stall)) begin
               PC_write_en     = 1'b0;
               IF_ID_write_en  = 1'b0;
               ID_EX_write_en  = 1'b0;
               EX_MEM_write_en = 1'b0;
               MEM_WB_write_en = 1'b0;
               if (state_q == ST_RUN) begin
                  state_d    = ST_WAIT;
                  wait_cnt_d = '0;
               end else if (wait_cnt_q == WAIT_LAST) begin
                  timeout_d = 1'b1;
                  state_d   = ST_RUN;
               end else begin
                  wait_cnt_d = wait_cnt_q + 8'd1;
               end
            end else begin
               // A stalled branch is re-evaluated next cycle, so its redirect is dropped now.
               state_d = ST_RUN;
               if (hazard) begin
                  PC_write_en    = 1'b0;
                  IF_ID_write_en = 1'b0;
                  stall_flush    = 1'b1;
               end else if (redirect) begin
                  IF_ID_flush = 1'b1;
               end
            end
         end
         default: state_d = ST_INIT;
      endcase

      stall_d = stall_q;
      flush_d = flush_q;
      if (state_q != ST_INIT && !PC_write_en && stall_q != CNT_MAX) stall_d = stall_q + CW'(1);
      if (state_q != ST_INIT && IF_ID_flush && flush_q != CNT_MAX)  flush_d = flush_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_INIT;
         init_cnt_q <= '0;
         wait_cnt_q <= '0;
         stall_q    <= '0;
         flush_q    <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         stall_q    <= stall_d;
         flush_q    <= flush_d;
         timeout_q  <= timeout_d;
      end
   end

   assign pipe_state   = state_q;
   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;
   assign mem_timeout  = timeout_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed table, corner sequences,
// and random traffic against a behavioural model of the hazard/flush/wait rules.
module tb_pipeline_hazard_ctrl;
   localparam int CW = 8;
   localparam int TO = 4;
   localparam int IC = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic reset;
   logic [4:0] Rs_ID, Rt_ID, Write_regnum_EX, Write_regnum_MEM;
   logic use_rs_ID, use_rt_ID, branch_ID, branch_taken_ID, jump_ID;
   logic data_read_EX, reg_write_EX, data_read_MEM, mem_req_MEM, dmem_ready;
   logic PC_write_en, IF_ID_write_en, IF_ID_flush, stall_flush;
   logic ID_EX_write_en, EX_MEM_write_en, MEM_WB_write_en, mem_timeout;
   logic [1:0] pipe_state;
   logic [CW-1:0] stall_cycles, flush_count;

   pipeline_hazard_ctrl #(.INIT_CYCLES(IC), .TIMEOUT(TO), .CW(CW)) dut (
      .clk(clk), .reset(reset), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
      .use_rs_ID(use_rs_ID), .use_rt_ID(use_rt_ID), .branch_ID(branch_ID),
      .branch_taken_ID(branch_taken_ID), .jump_ID(jump_ID),
      .data_read_EX(data_read_EX), .reg_write_EX(reg_write_EX),
      .Write_regnum_EX(Write_regnum_EX), .data_read_MEM(data_read_MEM),
      .Write_regnum_MEM(Write_regnum_MEM), .mem_req_MEM(mem_req_MEM),
      .dmem_ready(dmem_ready), .PC_write_en(PC_write_en),
      .IF_ID_write_en(IF_ID_write_en), .IF_ID_flush(IF_ID_flush),
      .stall_flush(stall_flush), .ID_EX_write_en(ID_EX_write_en),
      .EX_MEM_write_en(EX_MEM_write_en), .MEM_WB_write_en(MEM_WB_write_en),
      .pipe_state(pipe_state), .stall_cycles(stall_cycles),
      .flush_count(flush_count), .mem_timeout(mem_timeout)
   );

   always #5 clk = ~clk;

   // Control word order: {PC, IF_ID_we, IF_ID_flush, stall_flush, ID_EX_we, EX_MEM_we, MEM_WB_we}
   localparam logic [6:0] C_INIT   = 7'b0111111;
   localparam logic [6:0] C_FREEZE = 7'b0000000;
   localparam logic [6:0] C_STALL  = 7'b0001111;
   localparam logic [6:0] C_FLUSH  = 7'b1110111;
   localparam logic [6:0] C_NORM   = 7'b1100111;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: mode 0=INIT 1=RUN 2=MEM_WAIT
   bit m_valid = 0;
   int m_mode, m_init, m_wait, m_stall, m_flush;
   bit m_to;

   function automatic bit reads(input logic [4:0] r);
      return (r != 0) && ((use_rs_ID && Rs_ID == r) || (use_rt_ID && Rt_ID == r));
   endfunction

   function automatic logic [6:0] model_ctrl();
      bit hz;
      if (m_mode == 0) return C_INIT;
      if ((m_mode == 2 && !dmem_ready) || (m_mode == 1 && mem_req_MEM && !dmem_ready))
         return C_FREEZE;
      hz = (data_read_EX && reads(Write_regnum_EX)) ||
           (branch_ID && reg_write_EX && !data_read_EX && reads(Write_regnum_EX)) ||
           (branch_ID && data_read_MEM && reads(Write_regnum_MEM));
      if (hz) return C_STALL;
      if (branch_taken_ID || jump_ID) return C_FLUSH;
      return C_NORM;
   endfunction

   task automatic model_step();
      logic [6:0] c;
      c = model_ctrl();
      if (reset) begin
         m_valid = 1; m_mode = 0; m_init = 0; m_wait = 0;
         m_stall = 0; m_flush = 0; m_to = 0;
         return;
      end
      if (!m_valid) return;
      if (m_mode != 0) begin
         if (!c[6]) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
         if (c[4])  m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
      end
      case (m_mode)
         0: if (m_init == IC - 1) m_mode = 1; else m_init++;
         1: if (mem_req_MEM && !dmem_ready) begin m_mode = 2; m_wait = 0; end
         default: begin
            if (dmem_ready) m_mode = 1;
            else if (m_wait == TO - 1) begin m_to = 1; m_mode = 1; end
            else m_wait++;
         end
      endcase
   endtask

   function automatic logic [6:0] act_ctrl();
      return {PC_write_en, IF_ID_write_en, IF_ID_flush, stall_flush,
              ID_EX_write_en, EX_MEM_write_en, MEM_WB_write_en};
   endfunction

   task automatic settle();
      #1;
      if (m_valid) begin
         check("ctrl", 32'(act_ctrl()), 32'(model_ctrl()));
         check("pipe_state", 32'(pipe_state), 32'(m_mode));
         check("stall_cycles", 32'(stall_cycles), 32'(m_stall));
         check("flush_count", 32'(flush_count), 32'(m_flush));
         check("mem_timeout", 32'(mem_timeout), 32'(m_to));
      end
   endtask

   task automatic advance();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      reset = 0; Rs_ID = 0; Rt_ID = 0; use_rs_ID = 0; use_rt_ID = 0;
      branch_ID = 0; branch_taken_ID = 0; jump_ID = 0; data_read_EX = 0;
      reg_write_EX = 0; Write_regnum_EX = 0; data_read_MEM = 0;
      Write_regnum_MEM = 0; mem_req_MEM = 0; dmem_ready = 0;
   endtask

   task automatic do_reset_to_run();
      idle(); reset = 1;
      settle(); advance();
      idle();
      for (int i = 0; i < IC; i++) begin settle(); advance(); end
   endtask

   typedef struct {
      string name;
      logic [4:0] rs, rt, wex, wmem;
      logic urs, urt, br, bt, jmp, drex, rwex, drmem, mreq, rdy;
      logic [6:0] exp;
   } vec_t;

   function automatic vec_t mk(input string name, input int rs, input int urs, input int rt,
                               input int urt, input int br, input int bt, input int jmp,
                               input int drex, input int rwex, input int wex, input int drmem,
                               input int wmem, input int mreq, input int rdy,
                               input logic [6:0] exp);
      vec_t v;
      v.name = name; v.rs = 5'(rs); v.urs = 1'(urs); v.rt = 5'(rt); v.urt = 1'(urt);
      v.br = 1'(br); v.bt = 1'(bt); v.jmp = 1'(jmp); v.drex = 1'(drex); v.rwex = 1'(rwex);
      v.wex = 5'(wex); v.drmem = 1'(drmem); v.wmem = 5'(wmem); v.mreq = 1'(mreq);
      v.rdy = 1'(rdy); v.exp = exp;
      return v;
   endfunction

   vec_t tbl[12];

   initial begin
      //                rs urs rt urt br bt jmp drex rwex wex drm wm mreq rdy
      tbl[0]  = mk("idle",        0,0, 0,0, 0,0,0, 0,0, 0, 0,0, 0,0, C_NORM);
      tbl[1]  = mk("ld_use_rs",   5,1, 0,0, 0,0,0, 1,1, 5, 0,0, 0,0, C_STALL);
      tbl[2]  = mk("ld_rt_unused",0,0, 5,0, 0,0,0, 1,1, 5, 0,0, 0,0, C_NORM);
      tbl[3]  = mk("ld_r0",       0,1, 0,1, 0,0,0, 1,1, 0, 0,0, 0,0, C_NORM);
      tbl[4]  = mk("br_alu",      0,0, 3,1, 1,0,0, 0,1, 3, 0,0, 0,0, C_STALL);
      tbl[5]  = mk("alu_fwd",     0,0, 3,1, 0,0,0, 0,1, 3, 0,0, 0,0, C_NORM);
      tbl[6]  = mk("br_ld_mem",   7,1, 0,0, 1,0,0, 0,0, 0, 1,7, 0,0, C_STALL);
      tbl[7]  = mk("ld_mem_nobr", 7,1, 0,0, 0,0,0, 0,0, 0, 1,7, 0,0, C_NORM);
      tbl[8]  = mk("jump",        0,0, 0,0, 0,0,1, 0,0, 0, 0,0, 0,0, C_FLUSH);
      tbl[9]  = mk("br_taken",    1,1, 2,1, 1,1,0, 0,0, 0, 0,0, 0,0, C_FLUSH);
      tbl[10] = mk("br_alu_taken",4,1, 0,0, 1,1,0, 0,1, 4, 0,0, 0,0, C_STALL);
      tbl[11] = mk("mem_ready",   0,0, 0,0, 0,0,0, 0,0, 0, 0,0, 1,1, C_NORM);

      idle();
      @(negedge clk);

      // Reset and INIT drain
      reset = 1; settle(); advance(); settle(); advance();
      reset = 0;
      for (int i = 0; i < IC; i++) begin
         settle();
         check("init_state", 32'(pipe_state), 0);
         check("init_pc", 32'(PC_write_en), 0);
         check("init_sf", 32'(stall_flush), 1);
         advance();
      end
      settle();
      check("run_after_init", 32'(pipe_state), 1);
      check("stall_after_init", 32'(stall_cycles), 0);
      check("flush_after_init", 32'(flush_count), 0);

      // Load-use on r8, then the same with r0 as destination
      data_read_EX = 1; Write_regnum_EX = 8; Rs_ID = 8; use_rs_ID = 1;
      settle();
      check("lu_pc", 32'(PC_write_en), 0);
      check("lu_ifid_we", 32'(IF_ID_write_en), 0);
      check("lu_sf", 32'(stall_flush), 1);
      advance(); idle(); settle();
      check("lu_stall_cnt", 32'(stall_cycles), 1);
      data_read_EX = 1; Write_regnum_EX = 0; Rs_ID = 0; use_rs_ID = 1;
      settle();
      check("lu_r0_pc", 32'(PC_write_en), 1);
      check("lu_r0_sf", 32'(stall_flush), 0);
      advance();

      // Load to r9 feeding a branch: HZ_A then HZ_C, then the taken branch flushes
      idle(); branch_ID = 1; use_rt_ID = 1; Rt_ID = 9;
      data_read_EX = 1; reg_write_EX = 1; Write_regnum_EX = 9;
      settle(); check("ldbr_c1_pc", 32'(PC_write_en), 0); advance();
      data_read_EX = 0; reg_write_EX = 0; Write_regnum_EX = 0;
      data_read_MEM = 1; Write_regnum_MEM = 9;
      settle(); check("ldbr_c2_pc", 32'(PC_write_en), 0); advance();
      data_read_MEM = 0; Write_regnum_MEM = 0; branch_taken_ID = 1;
      settle();
      check("ldbr_flush", 32'(IF_ID_flush), 1);
      check("ldbr_pc", 32'(PC_write_en), 1);
      advance(); idle(); settle();
      check("ldbr_flush_cnt", 32'(flush_count), 1);
      check("ldbr_stall_cnt", 32'(stall_cycles), 3);

      // Load-use with a jump in the same cycle: stall wins
      data_read_EX = 1; Write_regnum_EX = 12; Rt_ID = 12; use_rt_ID = 1; jump_ID = 1;
      settle();
      check("luj_sf", 32'(stall_flush), 1);
      check("luj_flush", 32'(IF_ID_flush), 0);
      advance(); idle();

      // Table vectors in RUN
      foreach (tbl[i]) begin
         Rs_ID = tbl[i].rs; use_rs_ID = tbl[i].urs; Rt_ID = tbl[i].rt; use_rt_ID = tbl[i].urt;
         branch_ID = tbl[i].br; branch_taken_ID = tbl[i].bt; jump_ID = tbl[i].jmp;
         data_read_EX = tbl[i].drex; reg_write_EX = tbl[i].rwex;
         Write_regnum_EX = tbl[i].wex; data_read_MEM = tbl[i].drmem;
         Write_regnum_MEM = tbl[i].wmem; mem_req_MEM = tbl[i].mreq; dmem_ready = tbl[i].rdy;
         settle();
         check({"tbl_", tbl[i].name}, 32'(act_ctrl()), 32'(tbl[i].exp));
         advance();
      end
      idle();

      // Memory wait: not ready for 3 cycles, then ready
      mem_req_MEM = 1; dmem_ready = 0;
      for (int i = 0; i < 3; i++) begin
         settle();
         check("mw_ctrl", 32'(act_ctrl()), 32'(C_FREEZE));
         check("mw_state", 32'(pipe_state), (i == 0) ? 1 : 2);
         advance();
      end
      dmem_ready = 1;
      settle();
      check("mw_ready_ctrl", 32'(act_ctrl()), 32'(C_NORM));
      check("mw_ready_state", 32'(pipe_state), 2);
      advance(); idle(); settle();
      check("mw_exit_state", 32'(pipe_state), 1);

      // Timeout after TO wait cycles, sticky until reset
      mem_req_MEM = 1; dmem_ready = 0;
      settle(); advance();
      for (int i = 0; i < TO; i++) begin
         settle();
         check("to_state", 32'(pipe_state), 2);
         check("to_flag_low", 32'(mem_timeout), 0);
         advance();
      end
      idle(); settle();
      check("to_flag", 32'(mem_timeout), 1);
      check("to_state_run", 32'(pipe_state), 1);
      advance(); advance(); settle();
      check("to_sticky", 32'(mem_timeout), 1);
      mem_req_MEM = 1; dmem_ready = 0;
      settle(); advance();
      reset = 1; settle();
      check("rst_in_wait_pre", 32'(pipe_state), 2);
      advance(); idle(); settle();
      check("rst_in_wait_state", 32'(pipe_state), 0);
      check("rst_in_wait_to", 32'(mem_timeout), 0);
      check("rst_in_wait_cnt", 32'(stall_cycles), 0);
      for (int i = 0; i < IC; i++) advance();

      // Stall counter saturation
      mem_req_MEM = 1; dmem_ready = 0;
      for (int i = 0; i < CMAX + 40; i++) begin settle(); advance(); end
      settle();
      check("stall_sat", 32'(stall_cycles), CMAX);

      // Randomised traffic
      do_reset_to_run();
      for (int n = 0; n < 3000; n++) begin
         reset = ($urandom_range(0, 199) == 0);
         Rs_ID = 5'($urandom_range(0, 3)); Rt_ID = 5'($urandom_range(0, 3));
         Write_regnum_EX = 5'($urandom_range(0, 3)); Write_regnum_MEM = 5'($urandom_range(0, 3));
         use_rs_ID = 1'($urandom); use_rt_ID = 1'($urandom);
         branch_ID = 1'($urandom); branch_taken_ID = branch_ID & 1'($urandom);
         jump_ID = ($urandom_range(0, 7) == 0);
         data_read_EX = 1'($urandom); reg_write_EX = data_read_EX | 1'($urandom);
         data_read_MEM = 1'($urandom);
         mem_req_MEM = ($urandom_range(0, 3) == 0);
         dmem_ready = ($urandom_range(0, 9) < 6);
         settle();
         advance();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
